// File: rtl/hasio_enc_pipe_pkg.sv
// Shared hasio definitions: check-width derivation and codeword bit-index helpers,
// common to the coder, this encoder pipe and the matching decoder.
package hasio_enc_pipe_pkg;

  // Hamming check bits plus one overall-parity bit.
  function automatic int hasio_pw(input int dw);
    return $clog2(1 + dw + $clog2(1 + dw)) + 1;
  endfunction

  // Hamming position (1-based) of data bit idx: the idx-th non-power-of-two >= 3.
  function automatic int hasio_data_pos(input int idx);
    int cnt;
    cnt = 0;
    for (int p = 3; p < 65536; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) return p;
        cnt++;
      end
    end
    return 0;
  endfunction

  // Next codeword index, wrapping at the codeword width n.
  function automatic int hasio_wrap_inc(input int pos, input int n);
    return (pos + 1 >= n) ? 0 : pos + 1;
  endfunction

endpackage

// File: rtl/hasio_enc_pipe_coder.sv
// hasioCoder: combinational check generator. check[PW-2:0] are the Hamming
// parities, check[PW-1] is the overall parity across data and Hamming bits.
module hasioCoder
  import hasio_enc_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = hasio_pw(DW)
) (
  input  logic [DW-1:0] i_data,
  output logic [PW-1:0] o_check
);

  localparam int HW = PW - 1;

  logic [HW-1:0] w_pos [DW];
  logic [HW-1:0] w_ham;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_pos
      localparam int POS = hasio_data_pos(gi);
      assign w_pos[gi] = POS[HW-1:0];
    end
  endgenerate

  // Syndrome of a set data bit is its Hamming position, so parities are XOR of positions.
  always_comb begin
    w_ham = '0;
    for (int i = 0; i < DW; i++) begin
      if (i_data[i]) w_ham = w_ham ^ w_pos[i];
    end
  end

  assign o_check = {(^i_data) ^ (^w_ham), w_ham};

endmodule

// File: rtl/hasio_enc_pipe.sv
// hasio encoder pipe: one-cycle-latency encoder with output register, one-entry
// skid register, optional single/double bit-error injection and a transfer counter.
module hasio_enc_pipe
  import hasio_enc_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = hasio_pw(DW),
  parameter int CW = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic                       inj_en,
  input  logic                       inj_dbl,
  input  logic [$clog2(DW+PW)-1:0]   inj_pos,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [PW-1:0]              out_check,
  output logic [CW-1:0]              enc_count
);

  localparam int NW = DW + PW;
  localparam int PSW = $clog2(NW);

  // Handshake: a word moves on a port only in a cycle where valid && ready is high
  // at the rising edge; valid never waits on ready, and out_* hold while stalled.

  logic [PW-1:0]  w_check;
  logic [NW-1:0]  w_flip;
  logic [NW-1:0]  w_cw_in;
  logic [PSW-1:0] w_pos2;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_out_free;

  logic           w_out_valid_nxt;
  logic [NW-1:0]  w_out_cw_nxt;
  logic           w_skid_valid_nxt;
  logic [NW-1:0]  w_skid_cw_nxt;

  logic           r_out_valid;
  logic [NW-1:0]  r_out_cw;
  logic           r_skid_valid;
  logic [NW-1:0]  r_skid_cw;
  logic           r_in_ready;
  logic [CW-1:0]  r_count;

  hasioCoder #(.DW(DW), .PW(PW)) u_coder (
    .i_data  (in_data),
    .o_check (w_check)
  );

  assign w_pos2 = PSW'(hasio_wrap_inc(int'(inj_pos), NW));

  // Injection is applied after check generation, so the flipped word is a real error.
  always_comb begin
    w_flip = '0;
    if (inj_en && (int'(inj_pos) < NW)) begin
      w_flip[inj_pos] = 1'b1;
      if (inj_dbl) w_flip[w_pos2] = 1'b1;
    end
  end

  assign w_cw_in = {w_check, in_data} ^ w_flip;

  // r_in_ready comes out of reset set; masking with rst keeps it low during reset
  // and lets it be high in the very first cycle after release.
  assign in_ready   = r_in_ready && !rst;
  assign out_valid  = r_out_valid && !rst;
  assign out_data   = r_out_cw[DW-1:0];
  assign out_check  = r_out_cw[NW-1:DW];
  assign enc_count  = r_count;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // in_ready mirrors "skid empty", so an input transfer never coincides with a full skid.
  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_out_cw_nxt     = r_out_cw;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_cw_nxt    = r_skid_cw;
    if (w_out_free) begin
      if (r_skid_valid) begin
        w_out_valid_nxt  = 1'b1;
        w_out_cw_nxt     = r_skid_cw;
        w_skid_valid_nxt = 1'b0;
      end else if (w_in_fire) begin
        w_out_valid_nxt  = 1'b1;
        w_out_cw_nxt     = w_cw_in;
      end else begin
        w_out_valid_nxt  = 1'b0;
      end
    end else if (w_in_fire) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_cw_nxt    = w_cw_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_cw     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_cw    <= '0;
      r_in_ready   <= 1'b1;
      r_count      <= '0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_out_cw     <= w_out_cw_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_cw    <= w_skid_cw_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_out_fire) r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hasio_enc_pipe.sv
// Bench for hasio_enc_pipe: table of single-word vectors with hand-computed
// codewords and decode results, plus streaming/backpressure and reset sequences.
module tb_hasio_enc_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        inj_en;
  logic        inj_dbl;
  logic [5:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [6:0]  out_check;
  logic [15:0] enc_count;

  int n_vec = 0;
  int n_mis = 0;
  int hp[32];
  logic [38:0] exp_q[$];

  hasio_enc_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inj_en    (inj_en),
    .inj_dbl   (inj_dbl),
    .inj_pos   (inj_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_check (out_check),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic        dbl;
    logic [5:0]  pos;
    logic [31:0] e_data;
    logic [6:0]  e_check;
    logic        e_secr;
    logic        e_dede;
    logic [31:0] e_cdata;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Extended-Hamming decoder model: syndrome plus overall parity.
  task automatic hdec(input logic [31:0] d, input logic [6:0] c,
                      output logic secr, output logic dede, output logic [31:0] cd);
    logic [5:0] syn;
    logic       par;
    syn = c[5:0];
    for (int i = 0; i < 32; i++) if (d[i]) syn = syn ^ 6'(hp[i]);
    par  = (^d) ^ (^c);
    secr = par;
    dede = !par && (syn != 6'd0);
    cd   = d;
    if (par) for (int i = 0; i < 32; i++) if (6'(hp[i]) == syn) cd[i] = ~cd[i];
  endtask

  initial begin
    logic        secr, dede;
    logic [31:0] cdata;
    logic [31:0] s_data[4];
    logic [6:0]  s_chk[4];
    int          sent;
    int          p;

    p = 3;
    for (int i = 0; i < 32; i++) begin
      while ((p & (p - 1)) == 0) p++;
      hp[i] = p;
      p++;
    end

    //            data          en    dbl   pos    e_data        e_chk  secr  dede  cdata
    tbl[0]  = '{32'h0,        1'b0, 1'b0, 6'd0,  32'h0,        7'h00, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{32'h1,        1'b0, 1'b0, 6'd0,  32'h1,        7'h43, 1'b0, 1'b0, 32'h1};
    tbl[2]  = '{32'h0,        1'b1, 1'b0, 6'd0,  32'h1,        7'h00, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{32'h0,        1'b1, 1'b1, 6'd38, 32'h1,        7'h40, 1'b0, 1'b1, 32'h1};
    tbl[4]  = '{32'h0,        1'b1, 1'b1, 6'd40, 32'h0,        7'h00, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{32'h2,        1'b0, 1'b0, 6'd0,  32'h2,        7'h45, 1'b0, 1'b0, 32'h2};
    tbl[6]  = '{32'h3,        1'b0, 1'b0, 6'd0,  32'h3,        7'h06, 1'b0, 1'b0, 32'h3};
    tbl[7]  = '{32'h80000000, 1'b0, 1'b0, 6'd0,  32'h80000000, 7'h26, 1'b0, 1'b0, 32'h80000000};
    tbl[8]  = '{32'hFFFFFFFF, 1'b0, 1'b0, 6'd0,  32'hFFFFFFFF, 7'h18, 1'b0, 1'b0, 32'hFFFFFFFF};
    tbl[9]  = '{32'h10,       1'b0, 1'b0, 6'd0,  32'h10,       7'h49, 1'b0, 1'b0, 32'h10};
    tbl[10] = '{32'h1,        1'b1, 1'b0, 6'd35, 32'h1,        7'h4B, 1'b1, 1'b0, 32'h1};
    tbl[11] = '{32'h5,        1'b1, 1'b0, 6'd39, 32'h5,        7'h05, 1'b0, 1'b0, 32'h5};
    tbl[12] = '{32'h0,        1'b1, 1'b1, 6'd31, 32'h80000000, 7'h01, 1'b0, 1'b1, 32'h80000000};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_dbl = 1'b0;
    inj_pos = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_check", out_check, 0);
    chk("rst enc_count", enc_count, 0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready, 1);

    // Single-word vectors, out_ready held high
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = tbl[i].data;
      inj_en = tbl[i].en; inj_dbl = tbl[i].dbl; inj_pos = tbl[i].pos;
      @(negedge clk);
      in_valid = 1'b0; inj_en = 1'b0; inj_dbl = 1'b0; inj_pos = '0;
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d out_data", i), out_data, tbl[i].e_data);
      chk($sformatf("v%0d out_check", i), out_check, tbl[i].e_check);
      hdec(out_data, out_check, secr, dede, cdata);
      chk($sformatf("v%0d secr", i), secr, tbl[i].e_secr);
      chk($sformatf("v%0d dede", i), dede, tbl[i].e_dede);
      chk($sformatf("v%0d cdata", i), cdata, tbl[i].e_cdata);
      @(negedge clk);
      chk($sformatf("v%0d enc_count", i), enc_count, i + 1);
      chk($sformatf("v%0d drained", i), out_valid, 0);
    end

    // Streaming with out_ready low for the first 3 cycles
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_data[0] = 32'h1;        s_chk[0] = 7'h43;
    s_data[1] = 32'h2;        s_chk[1] = 7'h45;
    s_data[2] = 32'h3;        s_chk[2] = 7'h06;
    s_data[3] = 32'h80000000; s_chk[3] = 7'h26;
    sent = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? s_data[sent] : 32'h0;
      if (cyc == 1) chk("stream in_ready 2nd word", in_ready, 1);
      if (cyc == 2) begin
        chk("stream in_ready fall", in_ready, 0);
        chk("stream stall data", out_data, 32'h1);
        chk("stream stall check", out_check, 7'h43);
      end
      if (cyc == 4) chk("stream in_ready rise", in_ready, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stream extra word", {out_check, out_data}, 0);
        else chk($sformatf("stream word c%0d", cyc), {out_check, out_data}, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({s_chk[sent], s_data[sent]});
        sent++;
      end
    end
    in_valid = 1'b0;
    chk("stream words sent", sent, 4);
    chk("stream queue empty", exp_q.size(), 0);
    chk("stream enc_count", enc_count, 4);

    // Reset with output and skid registers both full
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD;
    @(negedge clk);
    in_data = 32'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full in_ready", in_ready, 0);
    chk("full out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst-mid out_valid during", out_valid, 0);
    @(negedge clk);
    chk("rst-mid out_valid", out_valid, 0);
    chk("rst-mid enc_count", enc_count, 0);
    chk("rst-mid out_data", out_data, 0);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst-mid in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst-mid no stale c%0d", k), out_valid, 0);
    end
    in_valid = 1'b1; in_data = 32'h2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst-mid fresh word", {out_check, out_data}, {7'h45, 32'h2});
    @(negedge clk);
    chk("rst-mid enc_count after", enc_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
